branch_seq_ctrl: RTL and testbench
==================================

// Module: branch_seq_ctrl
// PURPOSE
//  Sequences the ID-stage branch comparator: detects operand hazards, stalls ID until forwarded
//  operands are valid, drives the compare op code, and turns the compare result into a PC redirect
//  or a movz write enable. Tracks the branch-delay slot for the exception/interrupt unit.
//  Sits between decode, the hazard/forwarding logic and the PC-select mux.
// PARAMETERS
//  REG_AW         5   register-number width
//  ALU_USE_STALL  1   stall cycles when an ID compare operand is produced by an ALU op in EX
//  LOAD_USE_STALL 2   stall cycles when the producer is a load in EX; a load in MEM costs 1
//  STAT_W         32  width of the statistics counters (BRANCH_STATS_EN only)
// PORTS
//  clk          in  1       clock, rising edge
//  rst_n        in  1       asynchronous active-low reset
//  id_valid     in  1       valid instruction in ID
//  id_br_op     in  3       000 beq,001 bne,010 blez,011 bgtz,100 bltz,101 bgez,110 movz,111 none
//  id_rs,id_rt  in  REG_AW  source registers; rt is used only for beq/bne/movz
//  ex_wr_en,ex_is_load,ex_wr_reg    in 1,1,REG_AW   EX-stage producer
//  mem_wr_en,mem_is_load,mem_wr_reg in 1,1,REG_AW   MEM-stage producer
//  cmp_zero     in  1       result from the comparator
//  ext_stall    in  1       stall from elsewhere (md unit, memory); freezes this FSM
//  exc_flush    in  1       exception/eret flush; aborts any sequence in flight
//  cmp_op       out 3       op code to the comparator (111 when idle)
//  stall_id     out 1       hold PC and IF/ID
//  pc_sel_br    out 1       one-cycle pulse: take branch target
//  movz_we      out 1       one-cycle pulse: movz writes rd
//  id_in_dslot  out 1       the instruction now in ID is a delay slot (BD flag to CP0)
//  err_br_dslot out 1       one-cycle pulse: branch found in a delay slot
// BEHAVIOUR
//  Reset: state IDLE, cnt=0; all outputs 0 except cmp_op=111.
//  Hazard count h (combinational): 0 if no match; a match with r0 never counts.
//    EX load match -> LOAD_USE_STALL; EX ALU match or MEM load match -> ALU_USE_STALL.
//    When both rs and rt match, h is the larger value.
//  States IDLE, STALL, RESOLVE, DSLOT; cnt is 2 bits.
//  IDLE, id_valid and op!=111:
//    h==0 -> resolve in the same cycle, then go to DSLOT (go to IDLE for movz).
//    h>0  -> stall_id=1, cnt<=h-1, go to RESOLVE if h==1, otherwise go to STALL.
//  STALL: stall_id=1, cnt--. Go to RESOLVE when cnt==1. Total stall cycles = h.
//  Resolve (IDLE h==0, or RESOLVE): cmp_op=id_br_op.
//    Branch: pc_sel_br=cmp_zero. movz: movz_we=cmp_zero.
//    Next state is DSLOT for a branch (taken or not) and IDLE for movz.
//  DSLOT: id_in_dslot=1 for one cycle.
//    Branch op in ID: err_br_dslot=1, treated as not taken, no stall.
//    Then go to IDLE.
//  cmp_op holds id_br_op during IDLE-with-op, STALL and RESOLVE; it is 111 otherwise.
//  ext_stall=1: state and cnt hold; pc_sel_br and movz_we are forced 0.
//    stall_id passes through its own value OR'd is the caller's job.
//    Resolution completes on the first cycle with ext_stall=0.
//  exc_flush=1 overrides everything: in that cycle pc_sel_br=movz_we=stall_id=0, next state IDLE, cnt=0.
//  Reset mid-sequence: immediate return to reset values.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//    Adds outputs stat_br_cnt, stat_taken_cnt and stat_stall_cnt (STAT_W each).
//    They count resolved branches, taken branches and stall_id cycles.
//    Counters wrap at 2^STAT_W, reset to 0 and are frozen under exc_flush.
//  BRANCH_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package mips_branch_pkg:
//    CMP_BEQ..CMP_MOVZ and CMP_NONE op-code localparams.
//    FSM state encodings.
//    is_branch_op() function.
//  Sub-module branch_hazard_calc: purely combinational computation of h from the ID/EX/MEM fields.
//  The FSM, counter and stats live in branch_seq_ctrl.
// TESTING
//  beq, no hazards, cmp_zero=1 -> same cycle: pc_sel_br=1, stall_id=0; next cycle id_in_dslot=1.
//  bne rs=8 with EX ALU writing r8 -> 1 cycle of stall_id; pc_sel_br follows cmp_zero in the next cycle.
//  bgez rs=9 with EX load to r9 -> stall_id for 2 cycles, then resolve; ext_stall=1 during RESOLVE
//    delays the pulse by 1 cycle.
//  beq rt=0 with EX load to r0 -> no stall.
//  movz, cmp_zero=1 -> movz_we=1, no DSLOT.
//  Branch followed by a branch in the slot -> err_br_dslot=1, no pc_sel_br.
//  exc_flush asserted in STALL -> stall_id=0 that cycle, IDLE next; reset asserted mid-STALL
//    -> outputs at reset values asynchronously.
//  BRANCH_STATS_EN: 3 branches (2 taken, 3 stall cycles) -> counts 3/2/3.

Source files
------------

// File: rtl/mips_branch_pkg.sv
// Shared definitions for the ID-stage branch sequencer: comparator op codes,
// sequencer state encoding and op classification helpers.
package mips_branch_pkg;

    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLEZ = 3'b010;
    localparam logic [2:0] CMP_BGTZ = 3'b011;
    localparam logic [2:0] CMP_BLTZ = 3'b100;
    localparam logic [2:0] CMP_BGEZ = 3'b101;
    localparam logic [2:0] CMP_MOVZ = 3'b110;
    localparam logic [2:0] CMP_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_STALL   = 2'b01,
        ST_RESOLVE = 2'b10,
        ST_DSLOT   = 2'b11
    } br_state_e;

    // True for the six conditional branches (redirect the PC, own a delay slot).
    function automatic logic is_branch_op(input logic [2:0] op);
        return (op <= CMP_BGEZ);
    endfunction

    // True for ops that compare against rt as well as rs.
    function automatic logic uses_rt(input logic [2:0] op);
        return (op == CMP_BEQ) || (op == CMP_BNE) || (op == CMP_MOVZ);
    endfunction

endpackage

// File: rtl/branch_hazard_calc.sv
// Combinational hazard cost for the ID-stage compare operands: how many
// cycles ID must stall before the forwarded rs/rt values are usable.
module branch_hazard_calc
    import mips_branch_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned ALU_USE_STALL  = 1,
    parameter int unsigned LOAD_USE_STALL = 2
) (
    input  logic [2:0]        id_br_op_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_wr_en_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_wr_reg_i,
    input  logic              mem_wr_en_i,
    input  logic              mem_is_load_i,
    input  logic [REG_AW-1:0] mem_wr_reg_i,
    output logic [1:0]        h_o
);

    localparam logic [1:0] ALU_H  = 2'(ALU_USE_STALL);
    localparam logic [1:0] LOAD_H = 2'(LOAD_USE_STALL);

    logic [1:0] h_rs;
    logic [1:0] h_rt;

    // Per-operand cost; EX is the youngest producer so it is checked first, r0 never hazards.
    always_comb begin
        h_rs = '0;
        h_rt = '0;
        if (id_rs_i != '0) begin
            if (ex_wr_en_i && (ex_wr_reg_i == id_rs_i)) begin
                h_rs = ex_is_load_i ? LOAD_H : ALU_H;
            end else if (mem_wr_en_i && mem_is_load_i && (mem_wr_reg_i == id_rs_i)) begin
                h_rs = ALU_H;
            end
        end
        if ((id_rt_i != '0) && uses_rt(id_br_op_i)) begin
            if (ex_wr_en_i && (ex_wr_reg_i == id_rt_i)) begin
                h_rt = ex_is_load_i ? LOAD_H : ALU_H;
            end else if (mem_wr_en_i && mem_is_load_i && (mem_wr_reg_i == id_rt_i)) begin
                h_rt = ALU_H;
            end
        end
        h_o = (h_rs > h_rt) ? h_rs : h_rt;
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// ID-stage branch sequencer: stalls ID on compare-operand hazards, drives the
// comparator op code and turns the result into a PC redirect or movz write
// enable, and flags the delay-slot instruction for CP0.
// Optional: define BRANCH_STATS_EN to add branch/taken/stall statistics counters.
module branch_seq_ctrl
    import mips_branch_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned ALU_USE_STALL  = 1,
    parameter int unsigned LOAD_USE_STALL = 2,
    parameter int unsigned STAT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [2:0]        id_br_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_wr_reg,
    input  logic              mem_wr_en,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_wr_reg,
    input  logic              cmp_zero,
    input  logic              ext_stall,
    input  logic              exc_flush,
    output logic [2:0]        cmp_op,
    output logic              stall_id,
    output logic              pc_sel_br,
    output logic              movz_we,
    output logic              id_in_dslot,
    output logic              err_br_dslot
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_br_cnt,
    output logic [STAT_W-1:0] stat_taken_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    br_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] h;
    logic       has_op;
    logic       resolve;

    branch_hazard_calc #(
        .REG_AW         (REG_AW),
        .ALU_USE_STALL  (ALU_USE_STALL),
        .LOAD_USE_STALL (LOAD_USE_STALL)
    ) u_hazard (
        .id_br_op_i    (id_br_op),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .ex_wr_en_i    (ex_wr_en),
        .ex_is_load_i  (ex_is_load),
        .ex_wr_reg_i   (ex_wr_reg),
        .mem_wr_en_i   (mem_wr_en),
        .mem_is_load_i (mem_is_load),
        .mem_wr_reg_i  (mem_wr_reg),
        .h_o           (h)
    );

    assign has_op = id_valid && (id_br_op != CMP_NONE);

    // State register and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and outputs; ext_stall, exc_flush and reset are layered on top as overrides.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmp_op       = CMP_NONE;
        stall_id     = 1'b0;
        pc_sel_br    = 1'b0;
        movz_we      = 1'b0;
        id_in_dslot  = 1'b0;
        err_br_dslot = 1'b0;
        resolve      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (has_op) begin
                    cmp_op = id_br_op;
                    if (h == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall_id = 1'b1;
                        cnt_d    = h - 2'd1;
                        state_d  = (h == 2'd1) ? ST_RESOLVE : ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                stall_id = 1'b1;
                cmp_op   = id_br_op;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                cmp_op  = id_br_op;
                resolve = 1'b1;
            end
            ST_DSLOT: begin
                id_in_dslot  = 1'b1;
                err_br_dslot = id_valid && is_branch_op(id_br_op);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (resolve) begin
            if (is_branch_op(id_br_op)) begin
                pc_sel_br = cmp_zero;
                state_d   = ST_DSLOT;
            end else begin
                movz_we = (id_br_op == CMP_MOVZ) && cmp_zero;
                state_d = ST_IDLE;
            end
        end

        // An external stall freezes the sequence; the pulses fire once it lifts.
        if (ext_stall) begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            pc_sel_br    = 1'b0;
            movz_we      = 1'b0;
            err_br_dslot = 1'b0;
        end

        if (exc_flush) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            stall_id     = 1'b0;
            pc_sel_br    = 1'b0;
            movz_we      = 1'b0;
            err_br_dslot = 1'b0;
        end

        // Outputs are Mealy, so reset must mask them directly to take effect asynchronously.
        if (!rst_n) begin
            cmp_op       = CMP_NONE;
            stall_id     = 1'b0;
            pc_sel_br    = 1'b0;
            movz_we      = 1'b0;
            id_in_dslot  = 1'b0;
            err_br_dslot = 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    logic              br_done;
    logic [STAT_W-1:0] br_cnt_q, taken_cnt_q, stall_cnt_q;

    assign br_done = resolve && is_branch_op(id_br_op) && !ext_stall && !exc_flush;

    // Free-running wrap-around statistics, frozen while an exception flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (!exc_flush) begin
            if (br_done) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (br_done && cmp_zero) begin
                taken_cnt_q <= taken_cnt_q + 1'b1;
            end
            if (stall_id) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stat_br_cnt    = br_cnt_q;
    assign stat_taken_cnt = taken_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed self-checking bench for branch_seq_ctrl with hand-computed expectations.
module tb_branch_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_br_op;
    logic [4:0] id_rs, id_rt;
    logic       ex_wr_en, ex_is_load;
    logic [4:0] ex_wr_reg;
    logic       mem_wr_en, mem_is_load;
    logic [4:0] mem_wr_reg;
    logic       cmp_zero, ext_stall, exc_flush;
    logic [2:0] cmp_op;
    logic       stall_id, pc_sel_br, movz_we, id_in_dslot, err_br_dslot;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_cnt, stat_taken_cnt, stat_stall_cnt;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    branch_seq_ctrl #(
        .REG_AW         (5),
        .ALU_USE_STALL  (1),
        .LOAD_USE_STALL (2),
        .STAT_W         (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_br_op     (id_br_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_wr_en     (ex_wr_en),
        .ex_is_load   (ex_is_load),
        .ex_wr_reg    (ex_wr_reg),
        .mem_wr_en    (mem_wr_en),
        .mem_is_load  (mem_is_load),
        .mem_wr_reg   (mem_wr_reg),
        .cmp_zero     (cmp_zero),
        .ext_stall    (ext_stall),
        .exc_flush    (exc_flush),
        .cmp_op       (cmp_op),
        .stall_id     (stall_id),
        .pc_sel_br    (pc_sel_br),
        .movz_we      (movz_we),
        .id_in_dslot  (id_in_dslot),
        .err_br_dslot (err_br_dslot)
`ifdef BRANCH_STATS_EN
        ,
        .stat_br_cnt    (stat_br_cnt),
        .stat_taken_cnt (stat_taken_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid    = 1'b0;
        id_br_op    = 3'b111;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        ex_wr_en    = 1'b0;
        ex_is_load  = 1'b0;
        ex_wr_reg   = 5'd0;
        mem_wr_en   = 1'b0;
        mem_is_load = 1'b0;
        mem_wr_reg  = 5'd0;
        cmp_zero    = 1'b0;
        ext_stall   = 1'b0;
        exc_flush   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic cz);
        id_valid = 1'b1;
        id_br_op = op;
        id_rs    = rs;
        id_rt    = rt;
        cmp_zero = cz;
    endtask

    task automatic set_ex(input logic en, input logic ld, input logic [4:0] r);
        ex_wr_en   = en;
        ex_is_load = ld;
        ex_wr_reg  = r;
    endtask

    task automatic nop_in_slot();
        idle_inputs();
        id_valid = 1'b1;
        #1;
        chk("dslot_flag", id_in_dslot, 1'b1);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_cmp_op", cmp_op, 3'b111);
        chk("rst_stall", stall_id, 1'b0);
        chk("rst_pc_sel", pc_sel_br, 1'b0);
        chk("rst_dslot", id_in_dslot, 1'b0);
        rst_n = 1'b1;
        tick();

        // beq, no hazard, taken in the same cycle
        set_op(3'b000, 5'd1, 5'd2, 1'b1);
        #1;
        chk("beq_pc_sel", pc_sel_br, 1'b1);
        chk("beq_stall", stall_id, 1'b0);
        chk("beq_cmp_op", cmp_op, 3'b000);
        tick();
        idle_inputs();
        id_valid = 1'b1;
        #1;
        chk("beq_dslot", id_in_dslot, 1'b1);
        chk("beq_dslot_cmp_op", cmp_op, 3'b111);
        chk("beq_dslot_pc", pc_sel_br, 1'b0);
        tick();

        // bne rs=8 with EX ALU writing r8: one stall cycle, then not taken
        set_op(3'b001, 5'd8, 5'd3, 1'b1);
        set_ex(1'b1, 1'b0, 5'd8);
        #1;
        chk("bne_stall1", stall_id, 1'b1);
        chk("bne_pc_early", pc_sel_br, 1'b0);
        chk("bne_cmp_op", cmp_op, 3'b001);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        cmp_zero = 1'b0;
        #1;
        chk("bne_res_stall", stall_id, 1'b0);
        chk("bne_res_pc", pc_sel_br, 1'b0);
        chk("bne_res_cmp_op", cmp_op, 3'b001);
        tick();
        nop_in_slot();

        // bgez rs=9 with EX load to r9: two stall cycles; ext_stall delays resolve
        set_op(3'b101, 5'd9, 5'd0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd9);
        #1;
        chk("bgez_stall1", stall_id, 1'b1);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        #1;
        chk("bgez_stall2", stall_id, 1'b1);
        chk("bgez_stall2_cmp", cmp_op, 3'b101);
        chk("bgez_stall2_pc", pc_sel_br, 1'b0);
        tick();
        ext_stall = 1'b1;
        #1;
        chk("bgez_xs_stall", stall_id, 1'b0);
        chk("bgez_xs_pc", pc_sel_br, 1'b0);
        chk("bgez_xs_cmp", cmp_op, 3'b101);
        tick();
        ext_stall = 1'b0;
        #1;
        chk("bgez_res_pc", pc_sel_br, 1'b1);
        chk("bgez_res_stall", stall_id, 1'b0);
        tick();
        nop_in_slot();

        // beq with MEM load on rs and EX load on rt: larger cost (2) wins
        set_op(3'b000, 5'd5, 5'd6, 1'b0);
        set_ex(1'b1, 1'b1, 5'd6);
        mem_wr_en   = 1'b1;
        mem_is_load = 1'b1;
        mem_wr_reg  = 5'd5;
        #1;
        chk("max_stall1", stall_id, 1'b1);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        mem_wr_en = 1'b0;
        #1;
        chk("max_stall2", stall_id, 1'b1);
        tick();
        #1;
        chk("max_res_stall", stall_id, 1'b0);
        chk("max_res_pc", pc_sel_br, 1'b0);
        tick();
        nop_in_slot();

        // blez ignores rt: EX load to rt does not stall
        set_op(3'b010, 5'd1, 5'd6, 1'b1);
        set_ex(1'b1, 1'b1, 5'd6);
        #1;
        chk("blez_rt_stall", stall_id, 1'b0);
        chk("blez_rt_pc", pc_sel_br, 1'b1);
        tick();
        nop_in_slot();

        // bltz rs=7 with MEM ALU producer: forwarded, no stall
        set_op(3'b100, 5'd7, 5'd0, 1'b1);
        mem_wr_en   = 1'b1;
        mem_is_load = 1'b0;
        mem_wr_reg  = 5'd7;
        #1;
        chk("memalu_stall", stall_id, 1'b0);
        tick();
        nop_in_slot();

        // beq rt=0 with EX load to r0: no stall; then branch in slot
        set_op(3'b000, 5'd1, 5'd0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd0);
        #1;
        chk("r0_stall", stall_id, 1'b0);
        chk("r0_pc", pc_sel_br, 1'b1);
        tick();
        idle_inputs();
        set_op(3'b001, 5'd2, 5'd3, 1'b1);
        #1;
        chk("slot_br_err", err_br_dslot, 1'b1);
        chk("slot_br_pc", pc_sel_br, 1'b0);
        chk("slot_br_stall", stall_id, 1'b0);
        chk("slot_br_dslot", id_in_dslot, 1'b1);
        tick();
        idle_inputs();

        // movz, cmp_zero=1: write enable, no delay slot
        set_op(3'b110, 5'd4, 5'd5, 1'b1);
        #1;
        chk("movz_we", movz_we, 1'b1);
        chk("movz_pc", pc_sel_br, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("movz_no_dslot", id_in_dslot, 1'b0);
        chk("movz_we_done", movz_we, 1'b0);
        tick();

        // exc_flush in STALL
        set_op(3'b101, 5'd9, 5'd0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd9);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        exc_flush = 1'b1;
        #1;
        chk("flush_stall", stall_id, 1'b0);
        chk("flush_pc", pc_sel_br, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("flush_idle_stall", stall_id, 1'b0);
        chk("flush_idle_cmp", cmp_op, 3'b111);
        chk("flush_idle_dslot", id_in_dslot, 1'b0);
        tick();

        // reset mid-STALL: outputs drop immediately, inputs still asserting a branch
        set_op(3'b101, 5'd9, 5'd0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd9);
        tick();
        #1;
        chk("pre_rst_stall", stall_id, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall_id, 1'b0);
        chk("mid_rst_cmp", cmp_op, 3'b111);
        chk("mid_rst_pc", pc_sel_br, 1'b0);
        idle_inputs();
        #2;
        rst_n = 1'b1;
        tick();

`ifdef BRANCH_STATS_EN
        // three branches: 2 taken, 1+2 stall cycles
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        set_op(3'b000, 5'd1, 5'd2, 1'b1);
        tick();
        nop_in_slot();
        set_op(3'b001, 5'd8, 5'd3, 1'b1);
        set_ex(1'b1, 1'b0, 5'd8);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        tick();
        nop_in_slot();
        set_op(3'b101, 5'd9, 5'd0, 1'b0);
        set_ex(1'b1, 1'b1, 5'd9);
        tick();
        set_ex(1'b0, 1'b0, 5'd0);
        tick();
        tick();
        nop_in_slot();
        #1;
        chk("stat_br", stat_br_cnt, 32'd3);
        chk("stat_taken", stat_taken_cnt, 32'd2);
        chk("stat_stall", stat_stall_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
